// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: sign/magnitude/special flags, then regime/exponent/fraction.
// Latency 2 cycles, 1 result/cycle; a stalled output holds both stages and drops in_ready.
module posit_decode_pipe #(
  parameter int N  = 8,
  parameter int ES = 0,
  localparam int FRAC_W  = N - 3 - ES,
  localparam int SCALE_W = $clog2(N) + ES + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_posit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [SCALE_W-1:0] out_scale,
  output logic [FRAC_W-1:0]  out_frac,
  output logic               out_zero,
  output logic               out_nar
);

  localparam int RUN_W = $clog2(N) + 1;

  logic         s1_valid;
  logic         s1_sign;
  logic         s1_zero;
  logic         s1_nar;
  logic [N-2:0] s1_mag;

  logic         s2_valid;
  logic         s1_load;
  logic         s2_load;

  logic         low_zero;
  logic [N-2:0] mag_in;

  logic               run_bit;
  logic               run_stop;
  logic [RUN_W-1:0]   run_len;
  logic [RUN_W-1:0]   run_shift;
  logic [N-2:0]       post_regime;
  logic [SCALE_W-1:0] run_ext;
  logic [SCALE_W-1:0] k_val;
  logic [SCALE_W-1:0] scale_d;
  logic [FRAC_W-1:0]  frac_d;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Negative posits are decoded from their two's complement; the top bit drops out.
  assign low_zero = ~|in_posit[N-2:0];
  assign mag_in   = in_posit[N-1] ? (~in_posit[N-2:0] + 1'b1) : in_posit[N-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_mag   <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s1_load && in_valid) begin
        s1_sign <= in_posit[N-1];
        s1_zero <= low_zero && !in_posit[N-1];
        s1_nar  <= low_zero && in_posit[N-1];
        s1_mag  <= mag_in;
      end
    end
  end

  // Regime run length from the magnitude MSB downwards.
  always_comb begin
    run_bit  = s1_mag[N-2];
    run_len  = '0;
    run_stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!run_stop) begin
        if (s1_mag[i] == run_bit) run_len = run_len + 1'b1;
        else                      run_stop = 1'b1;
      end
    end
  end

  // Shifting out regime plus terminator leaves exponent then fraction at the top.
  always_comb begin
    run_shift   = run_len + 1'b1;
    post_regime = s1_mag << run_shift;
    run_ext     = SCALE_W'(run_len);
    k_val       = run_bit ? (run_ext - 1'b1) : (~run_ext + 1'b1);
    scale_d     = (k_val << ES) | SCALE_W'(post_regime >> (N - 1 - ES));
    frac_d      = post_regime[N-2-ES -: FRAC_W];
    if (s1_zero || s1_nar) begin
      scale_d = '0;
      frac_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_sign  <= 1'b0;
      out_scale <= '0;
      out_frac  <= '0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
    end else begin
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        out_sign  <= s1_sign;
        out_scale <= scale_d;
        out_frac  <= frac_d;
        out_zero  <= s1_zero;
        out_nar   <= s1_nar;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe at N=8/ES=0 and N=16/ES=1 against a bit-walking posit model.
module tb_posit_decode_pipe;

  typedef struct {
    logic        sgn;
    int          scale;
    logic [31:0] frac;
    logic        zero;
    logic        nar;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0]  in_posit8 = '0;
  logic        out_sign8, out_zero8, out_nar8;
  logic [3:0]  out_scale8;
  logic [4:0]  out_frac8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] in_posit16 = '0;
  logic        out_sign16, out_zero16, out_nar16;
  logic [5:0]  out_scale16;
  logic [11:0] out_frac16;

  int total = 0;
  int bad   = 0;

  posit_decode_pipe #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_posit(in_posit8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sign(out_sign8), .out_scale(out_scale8), .out_frac(out_frac8),
    .out_zero(out_zero8), .out_nar(out_nar8)
  );

  posit_decode_pipe #(.N(16), .ES(1)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_posit(in_posit16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sign(out_sign16), .out_scale(out_scale16), .out_frac(out_frac16),
    .out_zero(out_zero16), .out_nar(out_nar16)
  );

  // Walks the posit bit by bit: regime run, terminator, exponent, fraction.
  function automatic exp_t ref_decode(input int n, input int es, input logic [31:0] p);
    exp_t r;
    logic [31:0] mask, v;
    int pos, run, k, e, fw;
    logic rb;
    r.sgn = 1'b0; r.scale = 0; r.frac = '0; r.zero = 1'b0; r.nar = 1'b0;
    mask = (32'h1 << n) - 1;
    fw = n - 3 - es;
    if (p == 0) begin
      r.zero = 1'b1;
    end else if (p == (32'h1 << (n - 1))) begin
      r.nar = 1'b1;
      r.sgn = 1'b1;
    end else begin
      r.sgn = p[n-1];
      v = r.sgn ? ((~p + 1) & mask) : p;
      pos = n - 2;
      rb = v[pos];
      run = 0;
      while (pos >= 0 && v[pos] == rb) begin
        run++;
        pos--;
      end
      k = rb ? run - 1 : -run;
      pos--;
      e = 0;
      for (int i = 0; i < es; i++) begin
        e = e * 2 + ((pos >= 0 && v[pos]) ? 1 : 0);
        pos--;
      end
      for (int j = 0; j < fw; j++) begin
        if (pos >= 0 && v[pos]) r.frac[fw-1-j] = 1'b1;
        pos--;
      end
      r.scale = k * (1 << es) + e;
    end
    return r;
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      bad++; $display("FAIL reset_hs8 out_valid=%b in_ready=%b want 0/1", out_valid8, in_ready8);
    end
    total++;
    if ({out_sign8, out_scale8, out_frac8, out_zero8, out_nar8} !== '0) begin
      bad++; $display("FAIL reset_data8 got %b want all zero",
                      {out_sign8, out_scale8, out_frac8, out_zero8, out_nar8});
    end
    total++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1 ||
        {out_sign16, out_scale16, out_frac16, out_zero16, out_nar16} !== '0) begin
      bad++; $display("FAIL reset_16 out_valid=%b in_ready=%b data=%h want 0/1/0",
                      out_valid16, in_ready16, {out_sign16, out_scale16, out_frac16, out_zero16, out_nar16});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] vp [8];
    logic       vs [8];
    int         vsc [8];
    logic [4:0] vf [8];
    logic       vz [8];
    logic       vn [8];
    int         act;
    vp = '{8'h40, 8'h60, 8'h48, 8'hC0, 8'h01, 8'h7F, 8'h00, 8'h80};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vsc = '{0, 1, 0, 0, -6, 6, 0, 0};
    vf = '{5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    vz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid8 = 1'b1; in_posit8 = vp[i]; out_ready8 = 1'b1;
      #1;
      total++;
      if (in_ready8 !== 1'b1) begin
        bad++; $display("FAIL vec_accept[%h] in_ready=%b want 1", vp[i], in_ready8);
      end
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      total++;
      if (out_valid8 !== 1'b0) begin
        bad++; $display("FAIL vec_lat1[%h] out_valid=%b want 0", vp[i], out_valid8);
      end
      @(negedge clk);
      #1;
      act = $signed(out_scale8);
      total++;
      if (out_valid8 !== 1'b1 || out_sign8 !== vs[i] || act != vsc[i] || out_frac8 !== vf[i] ||
          out_zero8 !== vz[i] || out_nar8 !== vn[i]) begin
        bad++;
        $display("FAIL vec[%h] got v=%b s=%b sc=%0d f=%b z=%b n=%b want v=1 s=%b sc=%0d f=%b z=%b n=%b",
                 vp[i], out_valid8, out_sign8, act, out_frac8, out_zero8, out_nar8,
                 vs[i], vsc[i], vf[i], vz[i], vn[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, got = 0, cyc = 0;
    int gsc [3];
    logic [4:0] gf [3];
    while (got < 3 && cyc < 30) begin
      @(negedge clk);
      out_ready8 = !(cyc >= 2 && cyc <= 4);
      in_valid8 = (acc < 3);
      in_posit8 = (acc == 0) ? 8'h40 : (acc == 1) ? 8'h60 : 8'h48;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        total++;
        if (in_ready8 !== 1'b0 || acc != 2) begin
          bad++; $display("FAIL stall_ready cyc=%0d in_ready=%b accepts=%0d want 0/2", cyc, in_ready8, acc);
        end
        total++;
        if (out_valid8 !== 1'b1 || out_scale8 !== 4'd0 || out_frac8 !== 5'd0) begin
          bad++; $display("FAIL stall_hold cyc=%0d v=%b sc=%h f=%b want 1/0/0", cyc, out_valid8, out_scale8, out_frac8);
        end
      end
      if (in_valid8 && in_ready8) acc++;
      if (out_valid8 && out_ready8) begin
        gsc[got] = $signed(out_scale8);
        gf[got] = out_frac8;
        got++;
      end
      cyc++;
    end
    in_valid8 = 1'b0;
    total++;
    if (got != 3 || acc != 3) begin
      bad++; $display("FAIL b2b_count got=%0d accepted=%0d want 3/3", got, acc);
    end else begin
      total++;
      if (gsc[0] != 0 || gsc[1] != 1 || gsc[2] != 0 || gf[0] !== 5'd0 || gf[1] !== 5'd0 || gf[2] !== 5'b01000) begin
        bad++; $display("FAIL b2b_order sc=%0d,%0d,%0d f=%b,%b,%b want 0,1,0 00000,00000,01000",
                        gsc[0], gsc[1], gsc[2], gf[0], gf[1], gf[2]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid8 !== 1'b0) begin
        bad++; $display("FAIL b2b_dup cyc=%0d out_valid=%b want 0", i, out_valid8);
      end
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    out_ready8 = 1'b0; in_valid8 = 1'b1; in_posit8 = 8'h40;
    @(negedge clk);
    in_posit8 = 8'h60;
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    total++;
    if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
      bad++; $display("FAIL flush_full out_valid=%b in_ready=%b want 1/0", out_valid8, in_ready8);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      bad++; $display("FAIL flush_async out_valid=%b in_ready=%b want 0/1", out_valid8, in_ready8);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid8 = 1'b1; in_posit8 = 8'h7F; out_ready8 = 1'b1;
    #1;
    total++;
    if (in_ready8 !== 1'b1) begin
      bad++; $display("FAIL flush_first_accept in_ready=%b want 1", in_ready8);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    total++;
    if (out_valid8 !== 1'b0) begin
      bad++; $display("FAIL flush_stale out_valid=%b want 0", out_valid8);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid8 !== 1'b1 || out_scale8 !== 4'd6) begin
      bad++; $display("FAIL flush_first_result v=%b sc=%h want 1/6", out_valid8, out_scale8);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid8 !== 1'b0) begin
      bad++; $display("FAIL flush_tail out_valid=%b want 0", out_valid8);
    end
  endtask

  task automatic test_sweep8();
    exp_t q[$];
    exp_t e;
    int sent = 0, recv = 0, act;
    logic exp_ir;
    for (int cyc = 0; cyc < 4000 && recv < 256; cyc++) begin
      @(negedge clk);
      in_valid8 = (sent < 256) && ($urandom_range(3) != 0);
      in_posit8 = 8'(sent);
      out_ready8 = ($urandom_range(3) != 0);
      #1;
      exp_ir = (q.size() < 2) || out_ready8;
      total++;
      if (in_ready8 !== exp_ir) begin
        bad++; $display("FAIL sweep8_ready in_ready=%b want %b (in flight %0d)", in_ready8, exp_ir, q.size());
      end
      if (out_valid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL sweep8_spurious out_valid=1 with nothing in flight");
        end else begin
          e = q[0];
          act = $signed(out_scale8);
          if (out_sign8 !== e.sgn || act != e.scale || 32'(out_frac8) !== e.frac ||
              out_zero8 !== e.zero || out_nar8 !== e.nar) begin
            bad++;
            $display("FAIL sweep8 item %0d got s=%b sc=%0d f=%h z=%b n=%b want s=%b sc=%0d f=%h z=%b n=%b",
                     recv, out_sign8, act, out_frac8, out_zero8, out_nar8, e.sgn, e.scale, e.frac, e.zero, e.nar);
          end
          if (out_ready8) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(ref_decode(8, 0, 32'(in_posit8)));
        sent++;
      end
    end
    in_valid8 = 1'b0;
    total++;
    if (recv != 256) begin
      bad++; $display("FAIL sweep8_count received=%0d want 256", recv);
    end
  endtask

  task automatic test_sweep16();
    exp_t q[$];
    exp_t e;
    int sent = 0, recv = 0, act;
    logic exp_ir;
    logic [15:0] specials [5];
    specials = '{16'h0000, 16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF};
    for (int cyc = 0; cyc < 6000 && recv < 700; cyc++) begin
      @(negedge clk);
      in_valid16 = (sent < 700) && ($urandom_range(3) != 0);
      in_posit16 = (sent < 5) ? specials[sent] : 16'($urandom);
      out_ready16 = ($urandom_range(3) != 0);
      #1;
      exp_ir = (q.size() < 2) || out_ready16;
      total++;
      if (in_ready16 !== exp_ir) begin
        bad++; $display("FAIL sweep16_ready in_ready=%b want %b (in flight %0d)", in_ready16, exp_ir, q.size());
      end
      if (out_valid16) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL sweep16_spurious out_valid=1 with nothing in flight");
        end else begin
          e = q[0];
          act = $signed(out_scale16);
          if (out_sign16 !== e.sgn || act != e.scale || 32'(out_frac16) !== e.frac ||
              out_zero16 !== e.zero || out_nar16 !== e.nar) begin
            bad++;
            $display("FAIL sweep16 item %0d got s=%b sc=%0d f=%h z=%b n=%b want s=%b sc=%0d f=%h z=%b n=%b",
                     recv, out_sign16, act, out_frac16, out_zero16, out_nar16, e.sgn, e.scale, e.frac, e.zero, e.nar);
          end
          if (out_ready16) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
      if (in_valid16 && in_ready16) begin
        q.push_back(ref_decode(16, 1, 32'(in_posit16)));
        sent++;
      end
    end
    in_valid16 = 1'b0;
    total++;
    if (recv != 700) begin
      bad++; $display("FAIL sweep16_count received=%0d want 700", recv);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    test_sweep8();
    test_sweep16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
